cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter and driver. It replaces the fixed "grant equals request" single-unit tie-off with arbitration among NUM_REQ functional units (IEU, LSU, and others).
- Selects one requesting unit per cycle and registers its result payload onto the CDB.
- Drives en, data, addr, tag and redirect to the ROB, the reservation stations and the register map.
- Supports round-robin or fixed-priority modes, and flush.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2 or more).
- DATA_WIDTH, 32, result data width.
- ADDR_WIDTH, 32, redirect/branch address width.
- TAG_WIDTH, 6, ROB tag width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- i_flush  in  1  ROB redirect flush; cancels arbitration this cycle.
- i_req  in  NUM_REQ  per-unit request; bit k belongs to unit k.
- i_data  in  NUM_REQ*DATA_WIDTH  packed payload; unit k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed redirect address, same packing rule.
- i_tag  in  NUM_REQ*TAG_WIDTH  packed destination ROB tag, same packing rule.
- i_redirect  in  NUM_REQ  per-unit redirect (mispredict) flag.
- o_gnt  out  NUM_REQ  one-hot grant, combinational from i_req, rr_ptr and i_flush.
- o_cdb_en  out  1  CDB broadcast valid.
- o_cdb_data  out  DATA_WIDTH  broadcast result.
- o_cdb_addr  out  ADDR_WIDTH  broadcast redirect address.
- o_cdb_tag  out  TAG_WIDTH  broadcast tag.
- o_cdb_redirect  out  1  broadcast redirect flag.

Behaviour:
- State:
  - rr_ptr: $clog2(NUM_REQ) bits, the highest-priority index.
  - Output register: en, data, addr, tag, redirect.
- Reset (rst high at a clock edge):
  - rr_ptr = 0.
  - o_cdb_en, o_cdb_redirect = 0.
  - o_cdb_data, o_cdb_addr, o_cdb_tag = 0.
  - o_gnt = 0 while rst is high.
  - Reset mid-broadcast drops the pending broadcast; no partial output appears afterwards.
- Grant (combinational):
  - ARB_MODE=0: search i_req starting at rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit is granted.
  - ARB_MODE=1: the lowest set index is granted; rr_ptr is ignored.
  - At most one o_gnt bit is set.
  - o_gnt = 0 if i_req = 0, i_flush = 1 or rst = 1.
- Handshake:
  - A unit holds i_req and its payload stable until the cycle its o_gnt bit is high.
  - That cycle is the transfer; the unit may drop or replace its request the next cycle.
  - An ungranted unit keeps waiting; its payload is not consumed.
- Latency:
  - Granted payload is registered; o_cdb_* shows it exactly 1 cycle after the grant, with o_cdb_en = 1.
  - Back-to-back grants give one broadcast per cycle (full throughput).
- No grant in a cycle: next cycle o_cdb_en = 0 and data/addr/tag/redirect = 0, so the bus reads zero when idle.
- rr_ptr update (ARB_MODE=0 only):
  - On a grant to index g, rr_ptr = (g+1) mod NUM_REQ.
  - For non-power-of-two NUM_REQ, the wrap is explicit.
  - No grant leaves rr_ptr unchanged.
- Fairness: in round-robin mode, a continuously requesting unit is granted within NUM_REQ cycles.
- Flush:
  - No grant in the flush cycle, and the next cycle o_cdb_en = 0.
  - A broadcast already registered before the flush edge remains visible during the flush cycle; the ROB discards it.
  - rr_ptr is unchanged.
- i_redirect is passed through with the payload; it does not affect priority.

Test Plan:
- Reset sequence: assert rst for 2 cycles while i_req=4'b1111. Required: o_gnt=0 throughout; after release, o_cdb_en=0 and rr_ptr=0; the first grant is 4'b0001.
- Round-robin saturation (NUM_REQ=4, ARB_MODE=0): hold i_req=4'b1111 with tags 1,2,3,4. Required: grants 0001, 0010, 0100, 1000, 0001; o_cdb_tag sequence 1,2,3,4,1 lagging the grants by one cycle, with o_cdb_en high continuously.
- Skip and wrap: rr_ptr=3, i_req=4'b0101. Required: grant 0001 (index 0), then rr_ptr=1; the next cycle with i_req=4'b0100 grants 0100.
- Fixed priority (ARB_MODE=1): hold i_req=4'b1110. Required: always grants 0010; unit 3 never granted.
- Payload and redirect integrity: unit 2 requests with data=0xDEADBEEF, addr=0x00000100, tag=6'h2A, redirect=1. Required: the next cycle o_cdb_en=1, data=0xDEADBEEF, addr=0x100, tag=0x2A, redirect=1; the following idle cycle shows all zeros.
- Flush collision: i_flush=1 while i_req=4'b0011. Required: o_gnt=0; the next cycle o_cdb_en=0; rr_ptr unchanged; after the flush drops, unit rr_ptr is granted first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter and driver.
// Picks one requesting functional unit per cycle (round-robin or fixed
// priority) and registers its result payload onto the CDB one cycle later.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int ARB_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_flush,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  i_tag,
  input  logic [NUM_REQ-1:0]            i_redirect,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_cdb_en,
  output logic [DATA_WIDTH-1:0]         o_cdb_data,
  output logic [ADDR_WIDTH-1:0]         o_cdb_addr,
  output logic [TAG_WIDTH-1:0]          o_cdb_tag,
  output logic                          o_cdb_redirect
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Modular add for the priority pointer; wraps explicitly so that
  // non-power-of-two unit counts never index past the last unit.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int              off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return sum[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0]      rr_q, rr_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  redir_q, redir_d;

  logic [NUM_REQ-1:0]    gnt_s;
  logic [PTR_W-1:0]      gnt_idx_s;
  logic                  found_s;
  logic                  gnt_v_s;
  logic [PTR_W-1:0]      cand_s;

  // Grant search: first requester at or after rr_q (round-robin) or the
  // lowest requester (fixed priority); suppressed by reset and flush.
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ARB_MODE == 1) begin
        cand_s = k[PTR_W-1:0];
      end else begin
        cand_s = wrap_add(rr_q, k);
      end
      if (!found_s && i_req[cand_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        found_s   = found_s;
      end
    end
    gnt_v_s = found_s && !i_flush && !rst;
    if (gnt_v_s) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Next-state for the output register and pointer: the granted unit's
  // payload is muxed in, otherwise the bus is driven to zero.
  always_comb begin
    en_d    = gnt_v_s;
    data_d  = '0;
    addr_d  = '0;
    tag_d   = '0;
    redir_d = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_s[k]) begin
        data_d  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        addr_d  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        tag_d   = i_tag[k*TAG_WIDTH +: TAG_WIDTH];
        redir_d = i_redirect[k];
      end else begin
        redir_d = redir_d;
      end
    end
    if (ARB_MODE == 0 && gnt_v_s) begin
      rr_d = wrap_add(gnt_idx_s, 1);
    end else begin
      rr_d = rr_q;
    end
  end

  // State register: pointer plus registered CDB broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      redir_q <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      en_q    <= en_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      redir_q <= redir_d;
    end
  end

  assign o_gnt          = gnt_s;
  assign o_cdb_en       = en_q;
  assign o_cdb_data     = data_q;
  assign o_cdb_addr     = addr_q;
  assign o_cdb_tag      = tag_q;
  assign o_cdb_redirect = redir_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: a round-robin and a fixed-priority instance
// share stimulus and are checked against a behavioural model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 6;
  localparam int BW = 1 + 1 + TW + AW + DW;

  logic clk = 1'b0;
  logic rst;
  logic i_flush;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_data;
  logic [N*AW-1:0] i_addr;
  logic [N*TW-1:0] i_tag;
  logic [N-1:0]    i_redirect;

  logic [N-1:0] gnt_rr, gnt_fp;
  logic en_rr, en_fp, rd_rr, rd_fp;
  logic [DW-1:0] data_rr, data_fp;
  logic [AW-1:0] addr_rr, addr_fp;
  logic [TW-1:0] tag_rr, tag_fp;

  int n_cmp = 0;
  int n_err = 0;

  // model state, index 0 = round-robin instance, 1 = fixed-priority instance
  int            m_ptr [2];
  logic          e_en  [2];
  logic          e_rd  [2];
  logic [DW-1:0] e_data[2];
  logic [AW-1:0] e_addr[2];
  logic [TW-1:0] e_tag [2];
  int            last_g[2];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_req(i_req), .i_data(i_data),
    .i_addr(i_addr), .i_tag(i_tag), .i_redirect(i_redirect), .o_gnt(gnt_rr),
    .o_cdb_en(en_rr), .o_cdb_data(data_rr), .o_cdb_addr(addr_rr),
    .o_cdb_tag(tag_rr), .o_cdb_redirect(rd_rr));

  cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_req(i_req), .i_data(i_data),
    .i_addr(i_addr), .i_tag(i_tag), .i_redirect(i_redirect), .o_gnt(gnt_fp),
    .o_cdb_en(en_fp), .o_cdb_data(data_fp), .o_cdb_addr(addr_fp),
    .o_cdb_tag(tag_fp), .o_cdb_redirect(rd_fp));

  wire [BW-1:0] bus_rr = {en_rr, rd_rr, tag_rr, addr_rr, data_rr};
  wire [BW-1:0] bus_fp = {en_fp, rd_fp, tag_fp, addr_fp, data_fp};

  // Reference arbitration rule: which unit index wins, -1 for none.
  function automatic int ref_grant(input int m);
    if (rst || i_flush) return -1;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (m == 0) ? (m_ptr[m] + off) % N : off;
      if (i_req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int m);
    int g;
    logic [N-1:0] v;
    g = ref_grant(m);
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_bus(input int m);
    return {e_en[m], e_rd[m], e_tag[m], e_addr[m], e_data[m]};
  endfunction

  // Advance one clock and update the model from the inputs present at the edge.
  task automatic tick();
    int g[2];
    logic [DW-1:0] d[2];
    logic [AW-1:0] a[2];
    logic [TW-1:0] t[2];
    logic          r[2];
    logic          rs;
    rs = rst;
    for (int m = 0; m < 2; m++) begin
      g[m] = ref_grant(m);
      d[m] = '0; a[m] = '0; t[m] = '0; r[m] = 1'b0;
      if (g[m] >= 0) begin
        d[m] = i_data[g[m]*DW +: DW];
        a[m] = i_addr[g[m]*AW +: AW];
        t[m] = i_tag[g[m]*TW +: TW];
        r[m] = i_redirect[g[m]];
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rs) m_ptr[m] = 0;
      else if (g[m] >= 0 && m == 0) m_ptr[m] = (g[m] + 1) % N;
      e_en[m]   = (g[m] >= 0);
      e_data[m] = d[m];
      e_addr[m] = a[m];
      e_tag[m]  = t[m];
      e_rd[m]   = r[m];
      last_g[m] = g[m];
    end
    #1;
  endtask

  task automatic set_unit(input int k, input logic [DW-1:0] d, input logic [AW-1:0] a,
                          input logic [TW-1:0] t, input logic r);
    i_data[k*DW +: DW] = d;
    i_addr[k*AW +: AW] = a;
    i_tag[k*TW +: TW]  = t;
    i_redirect[k]      = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_flush = 1'b0; i_req = 4'b1111;
    for (int k = 0; k < N; k++) set_unit(k, $urandom, $urandom, TW'(k + 1), 1'b0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (gnt_rr !== 4'b0000 || gnt_fp !== 4'b0000) begin
        n_err++; $display("FAIL reset_gnt cyc%0d got rr=%b fp=%b want 0000", c, gnt_rr, gnt_fp);
      end
      if (c == 1) begin
        n_cmp++;
        if (bus_rr !== {BW{1'b0}} || bus_fp !== {BW{1'b0}}) begin
          n_err++; $display("FAIL reset_bus got rr=%h fp=%h want 0", bus_rr, bus_fp);
        end
      end
      tick();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (en_rr !== 1'b0 || bus_rr !== {BW{1'b0}}) begin
      n_err++; $display("FAIL post_reset_bus got %h want 0", bus_rr);
    end
    n_cmp++;
    if (gnt_rr !== 4'b0001 || gnt_rr !== exp_gnt(0)) begin
      n_err++; $display("FAIL first_gnt got %b want 0001", gnt_rr);
    end
  endtask

  task automatic test_rr_saturation();
    logic [N-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    i_req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (gnt_rr !== seq[c] || gnt_rr !== exp_gnt(0)) begin
        n_err++; $display("FAIL rr_sat_gnt cyc%0d got %b want %b", c, gnt_rr, seq[c]);
      end
      tick();
      n_cmp++;
      if (en_rr !== 1'b1 || tag_rr !== TW'(c % N + 1) || bus_rr !== exp_bus(0)) begin
        n_err++; $display("FAIL rr_sat_tag cyc%0d got en=%b tag=%0d want en=1 tag=%0d", c, en_rr, tag_rr, c % N + 1);
      end
    end
  endtask

  task automatic test_skip_wrap();
    i_req = 4'b0100;               // grant unit 2 -> pointer 3
    #1; tick();
    i_req = 4'b0101;
    #1;
    n_cmp++;
    if (m_ptr[0] != 3 || gnt_rr !== 4'b0001) begin
      n_err++; $display("FAIL skip_wrap_gnt got %b want 0001", gnt_rr);
    end
    tick();
    i_req = 4'b0100;
    #1;
    n_cmp++;
    if (gnt_rr !== 4'b0100 || gnt_rr !== exp_gnt(0)) begin
      n_err++; $display("FAIL skip_wrap_next got %b want 0100", gnt_rr);
    end
    tick();
  endtask

  task automatic test_fixed_priority();
    i_req = 4'b1110;
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < N; k++) set_unit(k, $urandom, $urandom, TW'($urandom), 1'($urandom));
      #1;
      n_cmp++;
      if (gnt_fp !== 4'b0010) begin
        n_err++; $display("FAIL fixed_gnt cyc%0d got %b want 0010", c, gnt_fp);
      end
      tick();
      n_cmp++;
      if (bus_fp !== exp_bus(1)) begin
        n_err++; $display("FAIL fixed_bus cyc%0d got %h want %h", c, bus_fp, exp_bus(1));
      end
    end
  endtask

  task automatic test_payload();
    i_req = 4'b0100;
    set_unit(2, 32'hDEADBEEF, 32'h00000100, 6'h2A, 1'b1);
    #1; tick();
    i_req = 4'b0000;
    #1;
    n_cmp++;
    if (en_rr !== 1'b1 || data_rr !== 32'hDEADBEEF || addr_rr !== 32'h00000100 ||
        tag_rr !== 6'h2A || rd_rr !== 1'b1) begin
      n_err++; $display("FAIL payload got en=%b d=%h a=%h t=%h r=%b want 1 deadbeef 100 2a 1",
                        en_rr, data_rr, addr_rr, tag_rr, rd_rr);
    end
    n_cmp++;
    if (bus_fp !== bus_rr || gnt_rr !== 4'b0000) begin
      n_err++; $display("FAIL payload_fp got %h want %h", bus_fp, exp_bus(1));
    end
    tick();
    n_cmp++;
    if (bus_rr !== {BW{1'b0}} || bus_fp !== {BW{1'b0}}) begin
      n_err++; $display("FAIL idle_zero got rr=%h fp=%h want 0", bus_rr, bus_fp);
    end
  endtask

  task automatic test_flush();
    int ptr_before;
    i_req = 4'b1000;               // broadcast lands in the flush cycle
    #1; tick();
    ptr_before = m_ptr[0];
    i_req = 4'b0011; i_flush = 1'b1;
    #1;
    n_cmp++;
    if (gnt_rr !== 4'b0000 || gnt_fp !== 4'b0000) begin
      n_err++; $display("FAIL flush_gnt got rr=%b fp=%b want 0000", gnt_rr, gnt_fp);
    end
    n_cmp++;
    if (en_rr !== 1'b1 || bus_rr !== exp_bus(0)) begin
      n_err++; $display("FAIL flush_prior_visible got %h want %h", bus_rr, exp_bus(0));
    end
    tick();
    i_flush = 1'b0;
    #1;
    n_cmp++;
    if (en_rr !== 1'b0 || en_fp !== 1'b0) begin
      n_err++; $display("FAIL flush_en got rr=%b fp=%b want 0", en_rr, en_fp);
    end
    n_cmp++;
    if (m_ptr[0] != ptr_before || gnt_rr !== 4'b0001) begin
      n_err++; $display("FAIL flush_resume got %b want 0001", gnt_rr);
    end
    tick();
  endtask

  task automatic test_reset_mid_broadcast();
    i_req = 4'b0010;
    #1; tick();
    rst = 1'b1; i_req = 4'b1111;
    #1; tick();
    rst = 1'b0; i_req = 4'b0000;
    #1;
    n_cmp++;
    if (bus_rr !== {BW{1'b0}} || bus_fp !== {BW{1'b0}}) begin
      n_err++; $display("FAIL reset_mid got rr=%h fp=%h want 0", bus_rr, bus_fp);
    end
    tick();
  endtask

  task automatic test_random();
    logic pend[N];
    int   waitc[N];
    for (int k = 0; k < N; k++) begin pend[k] = 1'b0; waitc[k] = 0; end
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(1, 0) == 1) begin
          pend[k] = 1'b1;
          set_unit(k, $urandom, $urandom, TW'($urandom), 1'($urandom));
        end
        i_req[k] = pend[k];
      end
      i_flush = ($urandom_range(7, 0) == 0);
      #1;
      n_cmp++;
      if (gnt_rr !== exp_gnt(0) || gnt_fp !== exp_gnt(1)) begin
        n_err++; $display("FAIL rand_gnt cyc%0d got rr=%b fp=%b want rr=%b fp=%b",
                          c, gnt_rr, gnt_fp, exp_gnt(0), exp_gnt(1));
      end
      tick();
      n_cmp++;
      if (bus_rr !== exp_bus(0) || bus_fp !== exp_bus(1)) begin
        n_err++; $display("FAIL rand_bus cyc%0d got rr=%h fp=%h want rr=%h fp=%h",
                          c, bus_rr, bus_fp, exp_bus(0), exp_bus(1));
      end
      for (int k = 0; k < N; k++) begin
        if (last_g[0] == k) begin
          pend[k] = 1'b0; waitc[k] = 0;
        end else if (pend[k] && !i_flush) begin
          waitc[k]++;
        end
        if (waitc[k] > N - 1) begin
          n_cmp++; n_err++;
          $display("FAIL fairness unit%0d waited %0d want <= %0d", k, waitc[k], N - 1);
          waitc[k] = 0;
        end
      end
    end
    i_flush = 1'b0;
  endtask

  initial begin
    m_ptr[0] = 0; m_ptr[1] = 0;
    for (int m = 0; m < 2; m++) begin
      e_en[m] = 1'b0; e_rd[m] = 1'b0; e_data[m] = '0; e_addr[m] = '0; e_tag[m] = '0; last_g[m] = -1;
    end
    i_data = '0; i_addr = '0; i_tag = '0; i_redirect = '0;
    test_reset();
    test_rr_saturation();
    test_skip_wrap();
    test_fixed_priority();
    test_payload();
    test_flush();
    test_reset_mid_broadcast();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
